btb_assoc_wq: RTL and testbench

- Parametrised, set-associative branch target buffer with age-based true LRU. Successor to the single-write BTB.
- Serves NUM_RD fetch lookups per cycle. Accepts up to NUM_WR resolved-branch updates per cycle into a small write queue, which drains one update per cycle into the array.
- Adds single-entry invalidation (decode finds a BTB hit on a non-branch) and whole-table flush.
- Sits between fetch (lookups) and the branch stack (resolves, invalidates).

---
 rtl/btb_assoc_wq_pkg.sv | 32 +++
 rtl/btb_wq.sv | 80 ++++++++
 rtl/btb_assoc_wq.sv | 188 ++++++++++++++++++
 tb/tb_btb_assoc_wq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_assoc_wq_pkg.sv
// ============================================================================
// btb_assoc_wq_pkg : shared BTB types and default geometry  |  Revision 1.0
// ============================================================================
`default_nettype none

package btb_assoc_wq_pkg;

  localparam int BTB_NUM_SETS  = 16;
  localparam int BTB_NUM_WAYS  = 4;
  localparam int BTB_WQ_DEPTH  = 4;
  localparam int BTB_IDX_BITS  = $clog2(BTB_NUM_SETS);
  localparam int BTB_TAG_BITS  = 30 - BTB_IDX_BITS;
  localparam int BTB_AGE_BITS  = $clog2(BTB_NUM_WAYS);

  typedef logic [BTB_IDX_BITS-1:0] BTB_IDX;
  typedef logic [BTB_TAG_BITS-1:0] BTB_TAG;
  typedef logic [BTB_AGE_BITS-1:0] BTB_AGE;

  typedef struct packed {
    logic        valid;
    BTB_TAG      tag;
    logic [31:0] target;
  } BTB_ENTRY;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } BTB_WQ_ENTRY;

endpackage

`default_nettype wire

// File: rtl/btb_wq.sv
// ============================================================================
// btb_wq : multi-push, single-pop circular FIFO for resolve updates  |  Rev 1.0
// ============================================================================
`default_nettype none

module btb_wq
  import btb_assoc_wq_pkg::*;
#(
  parameter int DEPTH    = BTB_WQ_DEPTH,
  parameter int NUM_PUSH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_PUSH-1:0]               push_valid,
  input  BTB_WQ_ENTRY [NUM_PUSH-1:0]        push_data,
  input  logic                              pop,
  output BTB_WQ_ENTRY                       head,
  output logic                              empty,
  output logic                              ready,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  BTB_WQ_ENTRY           r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_head;
  logic [PTR_BITS-1:0]   r_tail;
  logic [CNT_BITS-1:0]   r_count;

  logic [CNT_BITS-1:0]   w_num_push;
  logic [DEPTH-1:0]      w_wr_en;
  BTB_WQ_ENTRY           w_wr_data [DEPTH];
  logic                  w_pop;

  // Valid ports are packed into consecutive slots starting at the tail.
  always_comb begin : push_slots
    logic [PTR_BITS-1:0] slot;
    w_num_push = '0;
    w_wr_en    = '0;
    slot       = r_tail;
    for (int i = 0; i < DEPTH; i++) w_wr_data[i] = '0;
    for (int p = 0; p < NUM_PUSH; p++) begin
      slot = r_tail + w_num_push[PTR_BITS-1:0];
      if (push_valid[p] && ready) begin
        w_wr_en[slot]   = 1'b1;
        w_wr_data[slot] = push_data[p];
        w_num_push      = w_num_push + 1'b1;
      end
    end
  end

  assign w_pop = pop && !empty;
  assign empty = (r_count == '0);
  assign ready = (CNT_BITS'(DEPTH) - r_count) >= CNT_BITS'(NUM_PUSH);
  assign head  = r_mem[r_head];
  assign count = r_count;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + w_num_push[PTR_BITS-1:0];
      r_head  <= r_head + PTR_BITS'(w_pop);
      r_count <= r_count + w_num_push - CNT_BITS'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en[i]) r_mem[i] <= w_wr_data[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_assoc_wq.sv
// ============================================================================
// btb_assoc_wq : set-associative BTB, true-LRU ages, queued resolve writes
// Revision 1.0
// ============================================================================
`default_nettype none

module btb_assoc_wq
  import btb_assoc_wq_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int NUM_WAYS = BTB_NUM_WAYS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int WQ_DEPTH = BTB_WQ_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_RD-1:0][31:0]         rd_pc,
  output logic [NUM_RD-1:0]               rd_hit,
  output logic [NUM_RD-1:0][31:0]         rd_target,
  input  logic [NUM_WR-1:0]               wr_valid,
  input  logic [NUM_WR-1:0][31:0]         wr_pc,
  input  logic [NUM_WR-1:0][31:0]         wr_target,
  output logic                            wr_ready,
  input  logic                            inv_valid,
  input  logic [31:0]                     inv_pc,
  input  logic                            flush,
  output logic [$clog2(WQ_DEPTH):0]       wq_count
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int AGE_BITS = $clog2(NUM_WAYS);
  localparam logic [AGE_BITS-1:0] C_OLDEST = AGE_BITS'(NUM_WAYS - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
  } entry_t;

  entry_t              r_entry [NUM_SETS][NUM_WAYS];
  logic [AGE_BITS-1:0] r_age   [NUM_SETS][NUM_WAYS];

  // ---------------------------------------------------------------- write queue
  BTB_WQ_ENTRY [NUM_WR-1:0] w_push_data;
  BTB_WQ_ENTRY              w_head;
  logic                     w_wq_empty;
  logic                     w_drain;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_push
    assign w_push_data[g].pc     = wr_pc[g];
    assign w_push_data[g].target = wr_target[g];
  end

  btb_wq #(
    .DEPTH    (WQ_DEPTH),
    .NUM_PUSH (NUM_WR)
  ) u_wq (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push_valid (wr_valid),
    .push_data  (w_push_data),
    .pop        (w_drain),
    .head       (w_head),
    .empty      (w_wq_empty),
    .ready      (wr_ready),
    .count      (wq_count)
  );

  assign w_drain = !w_wq_empty;

  // ---------------------------------------------------------------- drain way select
  logic [IDX_BITS-1:0] w_d_idx;
  logic [TAG_BITS-1:0] w_d_tag;
  logic                w_d_hit;
  logic                w_free;
  logic [AGE_BITS-1:0] w_d_hit_way, w_free_way, w_old_way, w_d_way, w_d_age;

  assign w_d_idx = w_head.pc[IDX_BITS+1:2];
  assign w_d_tag = w_head.pc[31:IDX_BITS+2];

  // Hit way first, else lowest invalid way, else the way holding the oldest age.
  always_comb begin
    w_d_hit     = 1'b0;
    w_d_hit_way = '0;
    w_free      = 1'b0;
    w_free_way  = '0;
    w_old_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_entry[w_d_idx][w].valid && (r_entry[w_d_idx][w].tag == w_d_tag) && !w_d_hit) begin
        w_d_hit     = 1'b1;
        w_d_hit_way = AGE_BITS'(w);
      end
      if (!r_entry[w_d_idx][w].valid && !w_free) begin
        w_free     = 1'b1;
        w_free_way = AGE_BITS'(w);
      end
      if (r_age[w_d_idx][w] == C_OLDEST) w_old_way = AGE_BITS'(w);
    end
    w_d_way = w_d_hit ? w_d_hit_way : (w_free ? w_free_way : w_old_way);
  end

  assign w_d_age = r_age[w_d_idx][w_d_way];

  // ---------------------------------------------------------------- invalidate
  logic [IDX_BITS-1:0] w_i_idx;
  logic [TAG_BITS-1:0] w_i_tag;
  logic                w_i_hit, w_i_same, w_inv_en;
  logic [AGE_BITS-1:0] w_i_way, w_inv_way;

  assign w_i_idx = inv_pc[IDX_BITS+1:2];
  assign w_i_tag = inv_pc[31:IDX_BITS+2];

  always_comb begin
    w_i_hit = 1'b0;
    w_i_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_entry[w_i_idx][w].valid && (r_entry[w_i_idx][w].tag == w_i_tag)) begin
        w_i_hit = 1'b1;
        w_i_way = AGE_BITS'(w);
      end
    end
  end

  // A same-cycle drain of the same PC is caught here so the invalidate still wins.
  assign w_i_same  = w_drain && (w_i_idx == w_d_idx) && (w_i_tag == w_d_tag);
  assign w_inv_en  = inv_valid && (w_i_same || w_i_hit);
  assign w_inv_way = w_i_same ? w_d_way : w_i_way;

  // ---------------------------------------------------------------- array update
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_entry[s][w] <= '0;
          r_age[s][w]   <= AGE_BITS'(w);
        end
      end
    end else begin
      if (w_drain) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_BITS'(w) == w_d_way) begin
            r_entry[w_d_idx][w] <= entry_t'{valid: 1'b1, tag: w_d_tag, target: w_head.target};
            r_age[w_d_idx][w]   <= '0;
          end else if (r_age[w_d_idx][w] < w_d_age) begin
            r_age[w_d_idx][w] <= r_age[w_d_idx][w] + 1'b1;
          end
        end
      end
      if (w_inv_en) r_entry[w_i_idx][w_inv_way].valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- lookups
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic [31:0]         w_tgt;
    logic                w_unused_rd;

    assign w_idx       = rd_pc[g][IDX_BITS+1:2];
    assign w_tag       = rd_pc[g][31:IDX_BITS+2];
    assign w_unused_rd = ^rd_pc[g][1:0];

    always_comb begin
      w_hit = 1'b0;
      w_tgt = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (r_entry[w_idx][w].valid && (r_entry[w_idx][w].tag == w_tag)) begin
          w_hit = 1'b1;
          w_tgt = r_entry[w_idx][w].target;
        end
      end
    end

    assign rd_hit[g]    = w_hit;
    assign rd_target[g] = w_tgt;
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{w_head.pc[1:0], inv_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_btb_assoc_wq.sv
// ============================================================================
// tb_btb_assoc_wq : directed self-checking bench with drain scoreboard  |  Rev 1.0
// ============================================================================
`default_nettype none

module tb_btb_assoc_wq;

  localparam int NUM_SETS = 16;
  localparam int NUM_WAYS = 4;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int WQ_DEPTH = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_RD-1:0][31:0] rd_pc;
  logic [NUM_RD-1:0]       rd_hit;
  logic [NUM_RD-1:0][31:0] rd_target;
  logic [NUM_WR-1:0]       wr_valid;
  logic [NUM_WR-1:0][31:0] wr_pc;
  logic [NUM_WR-1:0][31:0] wr_target;
  logic                    wr_ready;
  logic                    inv_valid;
  logic [31:0]             inv_pc;
  logic                    flush;
  logic [2:0]              wq_count;

  always #5 clock = ~clock;

  btb_assoc_wq #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .WQ_DEPTH (WQ_DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_pc     (rd_pc),
    .rd_hit    (rd_hit),
    .rd_target (rd_target),
    .wr_valid  (wr_valid),
    .wr_pc     (wr_pc),
    .wr_target (wr_target),
    .wr_ready  (wr_ready),
    .inv_valid (inv_valid),
    .inv_pc    (inv_pc),
    .flush     (flush),
    .wq_count  (wq_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } wr_t;

  wr_t model_q[$];
  wr_t pend[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return 32'hB000_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Every set must hold each age value exactly once.
  function automatic bit ages_ok();
    for (int s = 0; s < NUM_SETS; s++) begin
      bit [NUM_WAYS-1:0] seen;
      seen = '0;
      for (int w = 0; w < NUM_WAYS; w++) seen[dut.r_age[s][w]] = 1'b1;
      if (seen != '1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic look(input logic [31:0] pc, input logic exp_hit,
                      input logic [31:0] exp_tgt, input string tag);
    for (int p = 0; p < NUM_RD; p++) rd_pc[p] = pc;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      chk({tag, "_hit"}, 32'(rd_hit[p]), 32'(exp_hit));
      chk({tag, "_tgt"}, rd_target[p], exp_tgt);
    end
  endtask

  task automatic push(input int port, input logic [31:0] pc, input logic [31:0] tgt);
    wr_t e;
    chk("wr_ready_at_push", 32'(wr_ready), 32'd1);
    wr_valid[port]  = 1'b1;
    wr_pc[port]     = pc;
    wr_target[port] = tgt;
    e.pc  = pc;
    e.tgt = tgt;
    pend.push_back(e);
  endtask

  // One clock: model the FIFO, then check occupancy, LRU sanity and the drained entry.
  task automatic tick();
    wr_t  d;
    bit   have;
    bit   killed;
    logic fl;
    have   = 1'b0;
    killed = 1'b0;
    fl     = flush;
    @(posedge clock);
    if (fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0) begin
        d      = model_q.pop_front();
        have   = 1'b1;
        killed = inv_valid && (inv_pc[31:2] == d.pc[31:2]);
      end
      foreach (pend[i]) model_q.push_back(pend[i]);
    end
    pend.delete();
    #1;
    wr_valid  = '0;
    inv_valid = 1'b0;
    flush     = 1'b0;
    chk("wq_count", 32'(wq_count), 32'(model_q.size()));
    chk("ages_perm", 32'(ages_ok()), 32'd1);
    if (have) look(d.pc, !killed, killed ? 32'd0 : d.tgt, "drained");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fill_pcs [5];
    fill_pcs = '{32'h0000, 32'h0040, 32'h0080, 32'h00C0, 32'h0100};

    reset     = 1'b1;
    rd_pc     = '0;
    wr_valid  = '0;
    wr_pc     = '0;
    wr_target = '0;
    inv_valid = 1'b0;
    inv_pc    = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: reset state
    look(32'h1000, 1'b0, 32'd0, "t1_reset");
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    chk("t1_wq_count", 32'(wq_count), 32'd0);
    chk("t1_ages", 32'(ages_ok()), 32'd1);

    // 2: single update, visible two cycles after the request
    push(0, 32'h1000, 32'h2000);
    tick();
    look(32'h1000, 1'b0, 32'd0, "t2_queued");
    tick();
    look(32'h1000, 1'b1, 32'h2000, "t2_hit");
    look(32'h1040, 1'b0, 32'd0, "t2_othertag");

    // 3: five tags into set 0 (already holding 0x1000)
    for (int i = 0; i < 5; i++) begin
      push(0, fill_pcs[i], tgt_of(fill_pcs[i]));
      tick();
    end
    tick();
    look(32'h0000, 1'b0, 32'd0, "t3_evicted");
    look(32'h0040, 1'b1, tgt_of(32'h0040), "t3_0040");
    look(32'h0080, 1'b1, tgt_of(32'h0080), "t3_0080");
    look(32'h00C0, 1'b1, tgt_of(32'h00C0), "t3_00C0");
    look(32'h0100, 1'b1, tgt_of(32'h0100), "t3_0100");

    // 4: refresh 0x0040, then allocate 0x0140 -> LRU victim is 0x0080
    push(0, 32'h0040, tgt_of(32'h0040));
    tick();
    push(0, 32'h0140, tgt_of(32'h0140));
    tick();
    tick();
    look(32'h0080, 1'b0, 32'd0, "t4_evicted");
    look(32'h0040, 1'b1, tgt_of(32'h0040), "t4_0040");
    look(32'h0140, 1'b1, tgt_of(32'h0140), "t4_0140");
    look(32'h00C0, 1'b1, tgt_of(32'h00C0), "t4_00C0");

    // 5: two pushes per cycle until backpressure; drain order follows targets
    push(0, 32'h2004, 32'h100);
    push(1, 32'h2004, 32'h200);
    tick();
    chk("t5_ready_c2", 32'(wr_ready), 32'd1);
    look(32'h2004, 1'b0, 32'd0, "t5_notyet");
    push(0, 32'h2004, 32'h300);
    push(1, 32'h2004, 32'h400);
    tick();
    chk("t5_ready_c3", 32'(wr_ready), 32'd0);
    tick();
    chk("t5_ready_c2b", 32'(wr_ready), 32'd1);
    tick();
    tick();
    look(32'h2004, 1'b1, 32'h400, "t5_final");

    // 6: drain and invalidate of the same PC in one cycle; then a plain invalidate
    push(0, 32'h3000, 32'h3333);
    tick();
    inv_valid = 1'b1;
    inv_pc    = 32'h3000;
    tick();
    inv_valid = 1'b1;
    inv_pc    = 32'h2004;
    tick();
    look(32'h2004, 1'b0, 32'd0, "t6_inv");
    look(32'h0140, 1'b1, tgt_of(32'h0140), "t6_other");

    // flush with two queued and one same-cycle push
    push(0, 32'h5004, tgt_of(32'h5004));
    push(1, 32'h5008, tgt_of(32'h5008));
    tick();
    flush = 1'b1;
    push(0, 32'h6004, tgt_of(32'h6004));
    tick();
    look(32'h0040, 1'b0, 32'd0, "t6_flush_0040");
    look(32'h0140, 1'b0, 32'd0, "t6_flush_0140");
    look(32'h1000 + 32'h4, 1'b0, 32'd0, "t6_flush_1004");
    tick();
    look(32'h5004, 1'b0, 32'd0, "t6_flush_5004");
    look(32'h6004, 1'b0, 32'd0, "t6_flush_6004");
    chk("t6_wr_ready", 32'(wr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
